// File: rtl/esc_pkg.sv
// esc_pkg: constants and state type shared by the ESC PWM generator and decoder
package esc_pkg;
  localparam int ESC_BASE = 50000;
  localparam int ESC_SCALE = 3;
  localparam int ESC_PERIOD = 2 ** 20;
  localparam int ESC_SPEED_W = 11;
  localparam int ESC_OFF_W = 10;
  localparam int ESC_TIMEOUT = 2 * ESC_PERIOD;
  localparam int ESC_VAL_W = 12;
  typedef enum logic [1:0] {ARM, WAIT_RISE, BASE_CNT, MEAS} esc_dec_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-flop synchronizer plus delay flop; ports clk, rst_n, pwm in; level, rise, fall out
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= pwm;
      s2 <= s1;
      d  <= s2;
    end
  assign level = s2;
  assign rise  = s2 & ~d;
  assign fall  = ~s2 & d;
endmodule

// File: rtl/esc_pwm_decoder.sv
// esc_pwm_decoder: recovers speed word from pulse high time H = BASE + SCALE*value; ports clk, rst_n, PWM in; speed_meas, vld, pulse_err, timeout out
module esc_pwm_decoder
  import esc_pkg::*;
#(
  parameter int BASE    = ESC_BASE,
  parameter int SCALE   = ESC_SCALE,
  parameter int TIMEOUT = ESC_TIMEOUT,
  parameter int VAL_W   = ESC_VAL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM,
  output logic [VAL_W-1:0] speed_meas,
  output logic             vld,
  output logic             pulse_err,
  output logic             timeout
);
  localparam int BW = $clog2(BASE + 1);
  localparam int PW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [VAL_W-1:0] VMAX = {VAL_W{1'b1}};
  esc_dec_state_t state, state_n;
  logic lvl, rise, fall;
  logic [BW-1:0] base_cnt, base_n;
  logic [PW-1:0] presc, presc_n;
  logic [VAL_W-1:0] val, val_n, speed_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [1:0] fill, fill_n;
  logic vld_n, err_n, to_n;
  pwm_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .pwm(PWM), .level(lvl), .rise(rise), .fall(fall));
  always_comb begin
    state_n = state;
    base_n  = base_cnt;
    presc_n = presc;
    val_n   = val;
    speed_n = speed_meas;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    // synchronizer outputs are reset values until two edges have sampled PWM
    fill_n  = (fill == 2'd2) ? fill : fill + 2'd1;
    case (state)
      ARM: if (fill == 2'd2 && !lvl) state_n = WAIT_RISE;
      WAIT_RISE: if (rise) begin
        state_n = BASE_CNT;
        base_n  = BW'(1);
      end
      BASE_CNT: if (fall) begin
        err_n   = 1'b1;
        state_n = WAIT_RISE;
      end else if (lvl) begin
        base_n = base_cnt + 1'b1;
        if (base_n == BW'(BASE)) begin
          state_n = MEAS;
          val_n   = '0;
          presc_n = '0;
        end
      end
      MEAS: if (fall) begin
        speed_n = val;
        vld_n   = 1'b1;
        state_n = WAIT_RISE;
      end else if (lvl) begin
        presc_n = (presc == PW'(SCALE - 1)) ? '0 : presc + 1'b1;
        val_n   = (presc == PW'(SCALE - 1) && val != VMAX) ? val + 1'b1 : val;
      end
      default: state_n = ARM;
    endcase
    tcnt_n = rise ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
    to_n   = vld_n ? 1'b0 : (timeout | (tcnt_n == TW'(TIMEOUT)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ARM;
      base_cnt   <= '0;
      presc      <= '0;
      val        <= '0;
      tcnt       <= '0;
      fill       <= '0;
      speed_meas <= '0;
      vld        <= 1'b0;
      pulse_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      base_cnt   <= base_n;
      presc      <= presc_n;
      val        <= val_n;
      tcnt       <= tcnt_n;
      fill       <= fill_n;
      speed_meas <= speed_n;
      vld        <= vld_n;
      pulse_err  <= err_n;
      timeout    <= to_n;
    end
endmodule
